// File: rtl/ingress_writer.sv
// Per-port ingress writer: validates and tags frame headers from one link and
// writes accepted frames byte-by-byte into that port's input FIFO.
module ingress_writer #(
  parameter logic [1:0] PORT_ID = 2'b01,
  parameter int         MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sop,
  input  logic       in_eop,
  output logic       in_ready,
  output logic [7:0] fifo_data,
  output logic       fifo_wrreq,
  input  logic       fifo_full,
  output logic [7:0] frame_count,
  output logic [7:0] drop_count,
  output logic [7:0] trunc_count,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state, state_n;
  logic [7:0] pay_cnt, pay_cnt_n;
  logic       trunc_flag, trunc_flag_n;
  logic [7:0] frame_n, drop_n, trunc_n, err_n;

  logic dest_ok, below_max, write_path, accept;

  // Ready may depend on the byte itself: only a byte headed for a full FIFO stalls.
  always_comb begin
    dest_ok    = (in_data[1:0] != 2'b00) && (in_data[1:0] != PORT_ID);
    below_max  = pay_cnt < MAX_LEN_B;
    write_path = in_sop ? dest_ok : ((state == FWD) && below_max);
    in_ready   = !reset && !(write_path && fifo_full);
    accept     = in_valid && in_ready;
    fifo_wrreq = accept && write_path;
    fifo_data  = in_sop ? {in_data[7:4], PORT_ID, in_data[1:0]} : in_data;
  end

  always_comb begin
    state_n      = state;
    pay_cnt_n    = pay_cnt;
    trunc_flag_n = trunc_flag;
    frame_n      = frame_count;
    drop_n       = drop_count;
    trunc_n      = trunc_count;
    err_n        = err_count;
    if (accept) begin
      if (in_sop) begin
        // A header outside IDLE abandons the current frame, then starts fresh.
        if (state != IDLE) err_n = err_count + 8'd1;
        trunc_flag_n = 1'b0;
        if (dest_ok) begin
          if (in_eop) begin
            state_n = IDLE;
            frame_n = frame_count + 8'd1;
          end else begin
            state_n   = FWD;
            pay_cnt_n = 8'd0;
          end
        end else begin
          drop_n  = drop_count + 8'd1;
          state_n = in_eop ? IDLE : DROP;
        end
      end else begin
        case (state)
          IDLE: err_n = err_count + 8'd1;
          FWD: begin
            if (below_max) pay_cnt_n = pay_cnt + 8'd1;
            else           trunc_flag_n = 1'b1;
            if (in_eop) begin
              state_n      = IDLE;
              frame_n      = frame_count + 8'd1;
              if (trunc_flag || !below_max) trunc_n = trunc_count + 8'd1;
              trunc_flag_n = 1'b0;
            end
          end
          DROP: if (in_eop) state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pay_cnt     <= 8'd0;
      trunc_flag  <= 1'b0;
      frame_count <= 8'd0;
      drop_count  <= 8'd0;
      trunc_count <= 8'd0;
      err_count   <= 8'd0;
    end else begin
      state       <= state_n;
      pay_cnt     <= pay_cnt_n;
      trunc_flag  <= trunc_flag_n;
      frame_count <= frame_n;
      drop_count  <= drop_n;
      trunc_count <= trunc_n;
      err_count   <= err_n;
    end
  end

endmodule

// File: tb/tb_ingress_writer.sv
// Directed bench for ingress_writer (PORT_ID=01, MAX_LEN=16): one task per
// scenario, FIFO writes captured mid-cycle into a queue.
module tb_ingress_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid, in_sop, in_eop;
  logic       in_ready;
  logic [7:0] fifo_data;
  logic       fifo_wrreq;
  logic       fifo_full;
  logic [7:0] frame_count, drop_count, trunc_count, err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_low = 0;
  logic [7:0] wr_q[$];
  int         wr_cyc[$];

  ingress_writer #(.PORT_ID(2'b01), .MAX_LEN(16)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_full(fifo_full),
    .frame_count(frame_count), .drop_count(drop_count),
    .trunc_count(trunc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: inputs change just after posedge, so negedge is stable.
  always @(negedge clk) begin
    if (fifo_wrreq) begin
      wr_q.push_back(fifo_data);
      wr_cyc.push_back(cyc);
    end
    if (in_valid && !in_ready && !reset) ready_low++;
  end

  // Present one byte from posedge+1 and hold it until accepted.
  task automatic send(input logic [7:0] d, input logic s, input logic e);
    logic acc;
    int n;
    n = 0;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout byte %0h never accepted", d);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; fifo_full = 1'b0;
    in_data = 8'h22; in_sop = 1'b1; in_eop = 1'b0; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0", in_ready); end
    checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrreq got %b expected 0", fifo_wrreq); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_frame got %0d expected 0", frame_count); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop got %0d expected 0", drop_count); end
    checks++; if (trunc_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_trunc got %0d expected 0", trunc_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_err got %0d expected 0", err_count); end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic test_forward;
    wr_q.delete(); wr_cyc.delete();
    send(8'h22, 1'b1, 1'b0);
    send(8'hA1, 1'b0, 1'b0);
    send(8'hA2, 1'b0, 1'b1);
    checks++;
    if (wr_q.size() != 3) begin
      errors++; $display("[TB] FAIL fwd_count got %0d expected 3", wr_q.size());
    end else begin
      checks++; if (wr_q[0] !== 8'h26) begin errors++; $display("[TB] FAIL fwd_hdr got %0h expected 26", wr_q[0]); end
      checks++; if (wr_q[1] !== 8'hA1) begin errors++; $display("[TB] FAIL fwd_p1 got %0h expected a1", wr_q[1]); end
      checks++; if (wr_q[2] !== 8'hA2) begin errors++; $display("[TB] FAIL fwd_p2 got %0h expected a2", wr_q[2]); end
      checks++; if (wr_cyc[2] - wr_cyc[0] != 2) begin errors++; $display("[TB] FAIL fwd_spacing got %0d expected 2", wr_cyc[2] - wr_cyc[0]); end
    end
    checks++; if (frame_count !== 8'd1) begin errors++; $display("[TB] FAIL fwd_frame got %0d expected 1", frame_count); end
    // Single-byte frame, header carries eop.
    wr_q.delete();
    send(8'h33, 1'b1, 1'b1);
    checks++; if (wr_q.size() != 1 || wr_q[0] !== 8'h37) begin errors++; $display("[TB] FAIL fwd_single got size %0d expected one 37", wr_q.size()); end
    checks++; if (frame_count !== 8'd2) begin errors++; $display("[TB] FAIL fwd_single_frame got %0d expected 2", frame_count); end
  endtask

  task automatic test_drop;
    wr_q.delete(); ready_low = 0;
    send(8'h01, 1'b1, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    send(8'h66, 1'b0, 1'b1);
    send(8'h00, 1'b1, 1'b1);
    checks++; if (wr_q.size() != 0) begin errors++; $display("[TB] FAIL drop_writes got %0d expected 0", wr_q.size()); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("[TB] FAIL drop_count got %0d expected 2", drop_count); end
    checks++; if (ready_low != 0) begin errors++; $display("[TB] FAIL drop_ready_low got %0d expected 0", ready_low); end
    checks++; if (err_count !== 8'd0 || frame_count !== 8'd2) begin errors++; $display("[TB] FAIL drop_side got err %0d frame %0d expected 0 2", err_count, frame_count); end
  endtask

  task automatic test_backpressure;
    wr_q.delete(); ready_low = 0;
    send(8'h12, 1'b1, 1'b0);
    send(8'hB1, 1'b0, 1'b0);
    in_data = 8'hB2; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1; fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_stall%0d got %b expected 0", k, in_ready); end
      checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("[TB] FAIL bp_wrreq_stall%0d got %b expected 0", k, fifo_wrreq); end
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || fifo_wrreq !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got ready %b wrreq %b expected 1 1", in_ready, fifo_wrreq); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(8'hB3, 1'b0, 1'b1);
    checks++; if (ready_low != 3) begin errors++; $display("[TB] FAIL bp_stall_cycles got %0d expected 3", ready_low); end
    checks++;
    if (wr_q.size() != 4) begin
      errors++; $display("[TB] FAIL bp_writes got %0d expected 4", wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== 8'h16 || wr_q[1] !== 8'hB1 || wr_q[2] !== 8'hB2 || wr_q[3] !== 8'hB3) begin
        errors++; $display("[TB] FAIL bp_data got %0h %0h %0h %0h expected 16 b1 b2 b3", wr_q[0], wr_q[1], wr_q[2], wr_q[3]);
      end
    end
    checks++; if (frame_count !== 8'd3) begin errors++; $display("[TB] FAIL bp_frame got %0d expected 3", frame_count); end
  endtask

  task automatic test_truncate;
    wr_q.delete();
    send(8'h43, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) send(8'(i), 1'b0, (i == 20));
    checks++; if (wr_q.size() != 17) begin errors++; $display("[TB] FAIL trunc_writes got %0d expected 17", wr_q.size()); end
    else begin
      checks++; if (wr_q[0] !== 8'h47 || wr_q[16] !== 8'd16) begin errors++; $display("[TB] FAIL trunc_data got %0h..%0h expected 47..10", wr_q[0], wr_q[16]); end
    end
    checks++; if (trunc_count !== 8'd1) begin errors++; $display("[TB] FAIL trunc_count got %0d expected 1", trunc_count); end
    checks++; if (frame_count !== 8'd4) begin errors++; $display("[TB] FAIL trunc_frame got %0d expected 4", frame_count); end
    // Exactly MAX_LEN payload bytes is not a truncation.
    wr_q.delete();
    send(8'h42, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) send(8'(i + 8'h80), 1'b0, (i == 16));
    checks++; if (wr_q.size() != 17) begin errors++; $display("[TB] FAIL exact_writes got %0d expected 17", wr_q.size()); end
    checks++; if (trunc_count !== 8'd1 || frame_count !== 8'd5) begin errors++; $display("[TB] FAIL exact_counts got trunc %0d frame %0d expected 1 5", trunc_count, frame_count); end
  endtask

  task automatic test_sop_in_fwd;
    wr_q.delete();
    send(8'h22, 1'b1, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'h83, 1'b1, 1'b0);
    checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL sopfwd_err got %0d expected 1", err_count); end
    checks++; if (frame_count !== 8'd5) begin errors++; $display("[TB] FAIL sopfwd_noframe got %0d expected 5", frame_count); end
    send(8'h99, 1'b0, 1'b1);
    checks++;
    if (wr_q.size() != 4) begin
      errors++; $display("[TB] FAIL sopfwd_writes got %0d expected 4", wr_q.size());
    end else begin
      checks++; if (wr_q[2] !== 8'h87 || wr_q[3] !== 8'h99) begin errors++; $display("[TB] FAIL sopfwd_data got %0h %0h expected 87 99", wr_q[2], wr_q[3]); end
    end
    checks++; if (frame_count !== 8'd6) begin errors++; $display("[TB] FAIL sopfwd_frame got %0d expected 6", frame_count); end
    wr_q.delete();
    send(8'h5A, 1'b0, 1'b0);
    checks++; if (err_count !== 8'd2 || wr_q.size() != 0) begin errors++; $display("[TB] FAIL stray got err %0d writes %0d expected 2 0", err_count, wr_q.size()); end
  endtask

  task automatic test_sop_in_drop;
    wr_q.delete();
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b1);
    checks++; if (err_count !== 8'd3 || drop_count !== 8'd3) begin errors++; $display("[TB] FAIL sopdrop got err %0d drop %0d expected 3 3", err_count, drop_count); end
    checks++; if (wr_q.size() != 1 || frame_count !== 8'd7) begin errors++; $display("[TB] FAIL sopdrop_fwd got writes %0d frame %0d expected 1 7", wr_q.size(), frame_count); end
    else begin
      checks++; if (wr_q[0] !== 8'h06) begin errors++; $display("[TB] FAIL sopdrop_data got %0h expected 06", wr_q[0]); end
    end
  endtask

  task automatic test_reset_midframe;
    send(8'h22, 1'b1, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_count !== 8'd0 || drop_count !== 8'd0 || trunc_count !== 8'd0 || err_count !== 8'd0) begin
      errors++; $display("[TB] FAIL rst_counts got %0d %0d %0d %0d expected 0 0 0 0", frame_count, drop_count, trunc_count, err_count);
    end
    @(posedge clk); #1;
    wr_q.delete();
    send(8'h13, 1'b1, 1'b0);
    send(8'hC0, 1'b0, 1'b1);
    checks++;
    if (wr_q.size() != 2) begin
      errors++; $display("[TB] FAIL rst_writes got %0d expected 2", wr_q.size());
    end else begin
      checks++; if (wr_q[0] !== 8'h17 || wr_q[1] !== 8'hC0) begin errors++; $display("[TB] FAIL rst_data got %0h %0h expected 17 c0", wr_q[0], wr_q[1]); end
    end
    checks++; if (frame_count !== 8'd1 || err_count !== 8'd0) begin errors++; $display("[TB] FAIL rst_after got frame %0d err %0d expected 1 0", frame_count, err_count); end
  endtask

  initial begin
    in_data = 8'h00; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    fifo_full = 1'b0; reset = 1'b1;
    test_reset;
    test_forward;
    test_drop;
    test_backpressure;
    test_truncate;
    test_sop_in_fwd;
    test_sop_in_drop;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
